// File: rtl/apb_cmd_arbiter_if.sv
// Bundle of the two requester ports and the APB-master command port of apb_cmd_arbiter.
// The arbiter connects through the slave modport; its environment connects through master.
interface apb_cmd_arbiter_if;
  logic       req0, req1;
  logic       rd0, rd1;
  logic [7:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1;
  logic       err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] gnt;
  logic       cmd_valid;
  logic       cmd_read;
  logic [7:0] cmd_waddr, cmd_raddr;
  logic [7:0] cmd_wdata;
  logic       cmd_busy;
  logic [7:0] cmd_rdata;

  modport slave (
    input  req0, req1, rd0, rd1, addr0, addr1, wdata0, wdata1, cmd_busy, cmd_rdata,
    output done0, done1, err0, err1, rdata0, rdata1, gnt,
           cmd_valid, cmd_read, cmd_waddr, cmd_raddr, cmd_wdata
  );

  modport master (
    output req0, req1, rd0, rd1, addr0, addr1, wdata0, wdata1, cmd_busy, cmd_rdata,
    input  done0, done1, err0, err1, rdata0, rdata1, gnt,
           cmd_valid, cmd_read, cmd_waddr, cmd_raddr, cmd_wdata
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Two-requester round-robin arbiter feeding one APB master command port,
// with a per-phase timeout that aborts a stuck transfer with an err pulse.
module apb_cmd_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic               clk,
  input logic               rst,
  apb_cmd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [1:0]      gnt_reg;
  logic            owner_reg;
  logic            last_reg;
  logic            rd_reg;
  logic [7:0]      addr_reg;
  logic [7:0]      wdata_reg;
  logic [7:0]      cnt_reg;
  logic            cmd_valid_reg;
  logic [1:0]      done_reg;
  logic [1:0]      err_reg;
  logic [1:0][7:0] rdata_reg;

  logic       pick;
  logic [7:0] cnt_inc;
  logic       cnt_expired;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick        = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
  assign cnt_inc     = cnt_reg + 8'd1;
  assign cnt_expired = (cnt_inc == TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= 2'b00;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      rd_reg        <= 1'b0;
      addr_reg      <= 8'h00;
      wdata_reg     <= 8'h00;
      cnt_reg       <= 8'h00;
      cmd_valid_reg <= 1'b0;
      done_reg      <= 2'b00;
      err_reg       <= 2'b00;
      rdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_reg     <= pick;
            gnt_reg       <= pick ? 2'b10 : 2'b01;
            rd_reg        <= pick ? bus.rd1 : bus.rd0;
            addr_reg      <= pick ? bus.addr1 : bus.addr0;
            wdata_reg     <= pick ? bus.wdata1 : bus.wdata0;
            cnt_reg       <= 8'h00;
            cmd_valid_reg <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmd_busy) begin
            cmd_valid_reg <= 1'b0;
            cnt_reg       <= 8'h00;
            state_reg     <= WAIT;
          end else if (cnt_expired) begin
            cmd_valid_reg       <= 1'b0;
            err_reg[owner_reg]  <= 1'b1;
            state_reg           <= RESP;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        WAIT: begin
          // A completion on the same edge as expiry still counts as success.
          if (!bus.cmd_busy) begin
            done_reg[owner_reg] <= 1'b1;
            if (rd_reg) begin
              rdata_reg[owner_reg] <= bus.cmd_rdata;
            end
            state_reg <= RESP;
          end else if (cnt_expired) begin
            err_reg[owner_reg] <= 1'b1;
            state_reg          <= RESP;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        RESP: begin
          done_reg  <= 2'b00;
          err_reg   <= 2'b00;
          gnt_reg   <= 2'b00;
          last_reg  <= owner_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.cmd_valid = cmd_valid_reg;
  assign bus.cmd_read  = rd_reg;
  assign bus.cmd_waddr = addr_reg;
  assign bus.cmd_raddr = addr_reg;
  assign bus.cmd_wdata = wdata_reg;
  assign bus.done0     = done_reg[0];
  assign bus.done1     = done_reg[1];
  assign bus.err0      = err_reg[0];
  assign bus.err1      = err_reg[1];
  assign bus.rdata0    = rdata_reg[0];
  assign bus.rdata1    = rdata_reg[1];

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Scoreboard bench for apb_cmd_arbiter: directed transfers push expected commands and
// responses; a negedge monitor pops and checks them against what the DUT presents.
module tb_apb_cmd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_cmd_arbiter_if bus ();

  apb_cmd_arbiter #(.TIMEOUT(8'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] gnt;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         gap;
  } cmd_t;

  typedef struct {
    logic [3:0] pulse;
    logic [7:0] r0;
    logic [7:0] r1;
    int         delta;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad   = 0;
  int n_resp = 0;

  // APB master model: busy rises one cycle after cmd_valid, falls lat cycles later.
  int         lat = 2;
  logic       hang = 1'b0;
  logic [7:0] prdata = 8'h00;
  int         mcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cmd_busy  <= 1'b0;
      bus.cmd_rdata <= 8'h00;
      mcnt          <= 0;
    end else if (!bus.cmd_busy) begin
      if (bus.cmd_valid) begin
        bus.cmd_busy <= 1'b1;
        mcnt         <= lat;
      end
    end else if (!hang) begin
      if (mcnt <= 1) begin
        bus.cmd_busy  <= 1'b0;
        bus.cmd_rdata <= prdata;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  logic [7:0] exp_rd0 = 8'h00;
  logic [7:0] exp_rd1 = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic who, input logic rd, input logic [7:0] addr,
                          input logic [7:0] wdata, input int gap);
    cmd_t c;
    c.gnt   = who ? 2'b10 : 2'b01;
    c.rd    = rd;
    c.addr  = addr;
    c.wdata = wdata;
    c.gap   = gap;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input logic who, input logic is_err, input logic rd, input int delta);
    resp_t r;
    if (!is_err && rd) begin
      if (who) exp_rd1 = prdata;
      else     exp_rd0 = prdata;
    end
    r.pulse = is_err ? (who ? 4'b1000 : 4'b0100) : (who ? 4'b0010 : 4'b0001);
    r.r0    = exp_rd0;
    r.r1    = exp_rd1;
    r.delta = delta;
    resp_q.push_back(r);
  endtask

  task automatic set_req(input logic who, input logic v, input logic rd,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (who) begin
      bus.req1 = v; bus.rd1 = rd; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = v; bus.rd0 = rd; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 400 && n_resp < target; i++) begin
      @(negedge clk); #1;
    end
    if (n_resp < target) begin
      total++; bad++;
      $display("FAIL wait_resp: got %0d responses expected %0d", n_resp, target);
    end
  endtask

  task automatic wait_fall();
    int i;
    for (i = 0; i < 100 && !bus.cmd_valid; i++) begin
      @(negedge clk); #1;
    end
    for (i = 0; i < 100 && bus.cmd_valid; i++) begin
      @(negedge clk); #1;
    end
    if (bus.cmd_valid) begin
      total++; bad++;
      $display("FAIL wait_fall: cmd_valid got 1 expected 0");
    end
  endtask

  task automatic xfer(input logic who, input logic rd, input logic [7:0] addr,
                      input logic [7:0] wdata, input int l, input logic [7:0] pd);
    int target;
    lat    = l;
    prdata = pd;
    push_cmd(who, rd, addr, wdata, 0);
    push_resp(who, 1'b0, rd, l);
    target = n_resp + 1;
    set_req(who, 1'b1, rd, addr, wdata);
    wait_resp(target);
    set_req(who, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT starts a command or pulses done/err.
  initial begin
    logic       prev_valid = 1'b0;
    logic       post_pending = 1'b0;
    int         cyc = 0, rise_cyc = 0, fall_cyc = 0, last_pulse_cyc = 0;
    logic [3:0] pulses;
    cmd_t       c;
    resp_t      r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid   = 1'b0;
        post_pending = 1'b0;
      end else begin
        cyc++;
        pulses = {bus.err1, bus.err0, bus.done1, bus.done0};
        if (post_pending) begin
          check("post_gnt", 64'(bus.gnt), 64'(2'b00));
          check("post_pulse", 64'(pulses), 64'(4'b0000));
          post_pending = 1'b0;
        end
        if (bus.cmd_valid && !prev_valid) begin
          rise_cyc = cyc;
          if (cmd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_cmd: got gnt=%0b expected no command", bus.gnt);
          end else begin
            c = cmd_q.pop_front();
            $display("cmd: gnt=%b rd=%0b waddr=%h raddr=%h wdata=%h", bus.gnt, bus.cmd_read,
                     bus.cmd_waddr, bus.cmd_raddr, bus.cmd_wdata);
            check("cmd_gnt", 64'(bus.gnt), 64'(c.gnt));
            check("cmd_read", 64'(bus.cmd_read), 64'(c.rd));
            check("cmd_waddr", 64'(bus.cmd_waddr), 64'(c.addr));
            check("cmd_raddr", 64'(bus.cmd_raddr), 64'(c.addr));
            check("cmd_wdata", 64'(bus.cmd_wdata), 64'(c.wdata));
            if (c.gap != 0) check("issue_gap", 64'(cyc - last_pulse_cyc), 64'(c.gap));
          end
        end
        if (!bus.cmd_valid && prev_valid) begin
          fall_cyc = cyc;
          check("valid_len", 64'(cyc - rise_cyc), 64'(2));
        end
        if (pulses != 4'b0000) begin
          n_resp++;
          last_pulse_cyc = cyc;
          post_pending   = 1'b1;
          check("one_pulse", 64'($countones(pulses)), 64'(1));
          if (resp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got pulses=%b expected none", pulses);
          end else begin
            r = resp_q.pop_front();
            $display("resp: pulses(err1,err0,done1,done0)=%b rdata0=%h rdata1=%h delay=%0d",
                     pulses, bus.rdata0, bus.rdata1, cyc - fall_cyc);
            check("resp_pulse", 64'(pulses), 64'(r.pulse));
            check("resp_rdata0", 64'(bus.rdata0), 64'(r.r0));
            check("resp_rdata1", 64'(bus.rdata1), 64'(r.r1));
            check("resp_valid_low", 64'(bus.cmd_valid), 64'(1'b0));
            check("resp_delay", 64'(cyc - fall_cyc), 64'(r.delta));
          end
        end
        prev_valid = bus.cmd_valid;
      end
    end
  end

  initial begin
    int target;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {bus.gnt, bus.cmd_valid, bus.cmd_read, bus.cmd_waddr, bus.cmd_raddr,
                         bus.cmd_wdata, bus.done0, bus.done1, bus.err0, bus.err1,
                         bus.rdata0, bus.rdata1}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Write from requester 0, then reads from both requesters.
    xfer(1'b0, 1'b0, 8'h10, 8'hA5, 2, 8'hEE);
    xfer(1'b0, 1'b1, 8'h33, 8'h00, 3, 8'h3C);
    xfer(1'b1, 1'b1, 8'h22, 8'h00, 1, 8'h5C);

    // Slave never becomes ready: timeout abort with err0, rdata0 kept.
    lat  = 1;
    hang = 1'b1;
    prdata = 8'hDD;
    push_cmd(1'b0, 1'b1, 8'h44, 8'h00, 0);
    push_resp(1'b0, 1'b1, 1'b1, 8);
    target = n_resp + 1;
    set_req(1'b0, 1'b1, 1'b1, 8'h44, 8'h00);
    wait_resp(target);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    hang = 1'b0;
    repeat (6) @(negedge clk);

    // Round robin from reset with both requests held for four transfers.
    do_reset();
    lat    = 1;
    prdata = 8'h77;
    push_cmd(1'b0, 1'b0, 8'h50, 8'h11, 0);
    push_resp(1'b0, 1'b0, 1'b0, 1);
    push_cmd(1'b1, 1'b1, 8'h60, 8'h00, 2);
    push_resp(1'b1, 1'b0, 1'b1, 1);
    push_cmd(1'b0, 1'b0, 8'h50, 8'h11, 2);
    push_resp(1'b0, 1'b0, 1'b0, 1);
    push_cmd(1'b1, 1'b1, 8'h60, 8'h00, 2);
    push_resp(1'b1, 1'b0, 1'b1, 1);
    target = n_resp + 4;
    #1;
    set_req(1'b0, 1'b1, 1'b0, 8'h50, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 8'h60, 8'h00);
    wait_resp(target);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Owner drops its request during WAIT; pending requester 1 follows right after.
    lat    = 3;
    prdata = 8'h42;
    push_cmd(1'b0, 1'b0, 8'h70, 8'h99, 0);
    push_resp(1'b0, 1'b0, 1'b0, 3);
    target = n_resp + 2;
    set_req(1'b0, 1'b1, 1'b0, 8'h70, 8'h99);
    wait_fall();
    push_cmd(1'b1, 1'b1, 8'h80, 8'h00, 2);
    push_resp(1'b1, 1'b0, 1'b1, 3);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 8'h80, 8'h00);
    wait_resp(target);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT: everything clears at once, no pulse follows.
    lat = 4;
    push_cmd(1'b0, 1'b1, 8'h90, 8'h00, 0);
    set_req(1'b0, 1'b1, 1'b1, 8'h90, 8'h00);
    wait_fall();
    check("mid_gnt", 64'(bus.gnt), 64'(2'b01));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outs", {bus.gnt, bus.cmd_valid, bus.cmd_read, bus.cmd_waddr,
                               bus.cmd_raddr, bus.cmd_wdata, bus.done0, bus.done1, bus.err0,
                               bus.err1, bus.rdata0, bus.rdata1}, 64'h0);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    xfer(1'b0, 1'b0, 8'hA0, 8'h5A, 2, 8'h00);
    repeat (3) @(negedge clk);

    check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
    check("resp_q_empty", 64'(resp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
